// File: rtl/count_seq_monitor.sv
// Self-checking sink for a free-running counter bus: acquires lock on a +1
// sequence, then tracks and reports mismatches, wrap-arounds and stalls.
module count_seq_monitor #(
  parameter int WIDTH       = 4,
  parameter int LOCK_N      = 3,
  parameter int STALL_LIMIT = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic             stall,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {SYNC, ACQ, TRACK} state_t;

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_N - 1);
  localparam logic [7:0]       REP_MAX   = 8'(STALL_LIMIT);
  localparam logic [7:0]       STALL_THR = 8'(STALL_LIMIT - 1);

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [7:0]         rep_q, rep_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               err_pulse_q, err_pulse_d;
  logic               stall_q, stall_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic               match;

  assign match = (cnt_in == exp_q);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    rep_d       = rep_q;
    prev_d      = prev_q;
    exp_d       = exp_q;
    err_pulse_d = 1'b0;
    stall_d     = stall_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    if (en) begin
      exp_d  = cnt_in + 1'b1;
      prev_d = cnt_in;
      // No previous sample exists in SYNC, so the repeat run starts fresh.
      if (state_q == SYNC || cnt_in != prev_q) rep_d = '0;
      else if (rep_q < REP_MAX)                rep_d = rep_q + 1'b1;
      stall_d = (rep_d >= STALL_THR);
      unique case (state_q)
        SYNC: begin
          run_d   = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (!match)                run_d = '0;
          else if (run_q == RUN_LAST) begin
            run_d   = '0;
            state_d = TRACK;
          end else                   run_d = run_q + 1'b1;
        end
        TRACK: begin
          if (match) begin
            if (cnt_in == '0 && !(&wrap_cnt_q)) wrap_cnt_d = wrap_cnt_q + 1'b1;
          end else begin
            err_pulse_d = 1'b1;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
            run_d   = '0;
            state_d = ACQ;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      run_q       <= '0;
      rep_q       <= '0;
      prev_q      <= '0;
      exp_q       <= '0;
      err_pulse_q <= 1'b0;
      stall_q     <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      rep_q       <= rep_d;
      prev_q      <= prev_d;
      exp_q       <= exp_d;
      err_pulse_q <= err_pulse_d;
      stall_q     <= stall_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked     = (state_q == TRACK);
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_cnt_q;
  assign wrap_count = wrap_cnt_q;
  assign stall      = stall_q;
  assign expected   = exp_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor; a second instance with CNT_W=2
// shares the stimulus and is used for saturation checks.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] cnt_in = '0;

  logic       locked, err_pulse, stall;
  logic [7:0] err_count, wrap_count;
  logic [3:0] expected;
  logic       d2_locked, d2_err_pulse, d2_stall;
  logic [1:0] d2_err_count, d2_wrap_count;
  logic [3:0] d2_expected;

  int tests = 0;
  int fails = 0;

  count_seq_monitor #(.WIDTH(4), .LOCK_N(3), .STALL_LIMIT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .stall(stall), .expected(expected)
  );

  count_seq_monitor #(.WIDTH(4), .LOCK_N(3), .STALL_LIMIT(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in),
    .locked(d2_locked), .err_pulse(d2_err_pulse), .err_count(d2_err_count),
    .wrap_count(d2_wrap_count), .stall(d2_stall), .expected(d2_expected)
  );

  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [3:0] v);
    en = e;
    cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] snap();
    return {locked, err_pulse, stall, expected, err_count, wrap_count};
  endfunction

  function automatic logic [22:0] mk(input logic l, input logic p, input logic s,
                                     input logic [3:0] e, input logic [7:0] ec,
                                     input logic [7:0] wc);
    return {l, p, s, e, ec, wc};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 4'd9);
    tests++;
    if (snap() !== mk(0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL reset got=%h exp=%h", snap(), mk(0, 0, 0, 0, 0, 0));
    end
    tests++;
    if ({d2_locked, d2_err_pulse, d2_stall, d2_expected, d2_err_count, d2_wrap_count} !== 11'd0) begin
      fails++; $display("FAIL reset_d2 got_err=%0d exp=0", d2_err_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i));
      tests++;
      if (snap() !== mk(i >= 3, 0, 0, 4'(i + 1), 0, 0)) begin
        fails++; $display("FAIL acquire[%0d] got=%h exp=%h", i, snap(), mk(i >= 3, 0, 0, 4'(i + 1), 0, 0));
      end
    end
  endtask

  task automatic test_wrap();
    for (int v = 5; v < 16; v++) begin
      step(1'b1, 4'(v));
      tests++;
      if (snap() !== mk(1, 0, 0, 4'(v + 1), 0, 0)) begin
        fails++; $display("FAIL wrap_pre[%0d] got=%h exp=%h", v, snap(), mk(1, 0, 0, 4'(v + 1), 0, 0));
      end
    end
    step(1'b1, 4'd0);
    tests++;
    if (snap() !== mk(1, 0, 0, 1, 0, 1)) begin
      fails++; $display("FAIL wrap_zero got=%h exp=%h", snap(), mk(1, 0, 0, 1, 0, 1));
    end
    step(1'b1, 4'd1);
    tests++;
    if (snap() !== mk(1, 0, 0, 2, 0, 1)) begin
      fails++; $display("FAIL wrap_post got=%h exp=%h", snap(), mk(1, 0, 0, 2, 0, 1));
    end
  endtask

  task automatic test_mismatch();
    logic [3:0] seq [4] = '{4'd9, 4'd10, 4'd11, 4'd12};
    logic [22:0] want [4];
    want[0] = mk(0, 1, 0, 10, 1, 1);
    want[1] = mk(0, 0, 0, 11, 1, 1);
    want[2] = mk(0, 0, 0, 12, 1, 1);
    want[3] = mk(1, 0, 0, 13, 1, 1);
    for (int v = 2; v < 7; v++) step(1'b1, 4'(v));
    tests++;
    if (snap() !== mk(1, 0, 0, 7, 0, 1)) begin
      fails++; $display("FAIL mis_pre got=%h exp=%h", snap(), mk(1, 0, 0, 7, 0, 1));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i]);
      tests++;
      if (snap() !== want[i]) begin
        fails++; $display("FAIL mismatch[%0d] got=%h exp=%h", i, snap(), want[i]);
      end
    end
  endtask

  task automatic test_stall();
    for (int v = 13; v < 23; v++) step(1'b1, 4'(v));
    step(1'b1, 4'd7);
    tests++;
    if (snap() !== mk(1, 0, 0, 8, 1, 2)) begin
      fails++; $display("FAIL stall_pre got=%h exp=%h", snap(), mk(1, 0, 0, 8, 1, 2));
    end
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 4'd7);
      tests++;
      if (snap() !== mk(0, k == 1, k >= 7, 8, 2, 2)) begin
        fails++; $display("FAIL stall_rep[%0d] got=%h exp=%h", k, snap(), mk(0, k == 1, k >= 7, 8, 2, 2));
      end
    end
    step(1'b1, 4'd8);
    tests++;
    if (snap() !== mk(0, 0, 0, 9, 2, 2)) begin
      fails++; $display("FAIL stall_clear got=%h exp=%h", snap(), mk(0, 0, 0, 9, 2, 2));
    end
    step(1'b1, 4'd9);
    step(1'b1, 4'd10);
    tests++;
    if (snap() !== mk(1, 0, 0, 11, 2, 2)) begin
      fails++; $display("FAIL stall_relock got=%h exp=%h", snap(), mk(1, 0, 0, 11, 2, 2));
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'($urandom_range(15)));
      tests++;
      if (snap() !== mk(1, 0, 0, 11, 2, 2)) begin
        fails++; $display("FAIL en_hold[%0d] got=%h exp=%h", i, snap(), mk(1, 0, 0, 11, 2, 2));
      end
    end
    step(1'b1, 4'd11);
    tests++;
    if (snap() !== mk(1, 0, 0, 12, 2, 2)) begin
      fails++; $display("FAIL en_resume got=%h exp=%h", snap(), mk(1, 0, 0, 12, 2, 2));
    end
  endtask

  task automatic test_saturate();
    logic [3:0] e, b;
    rst = 1'b1;
    step(1'b1, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i));
    tests++;
    if (d2_locked !== 1'b1) begin
      fails++; $display("FAIL sat_lock got=%0b exp=1", d2_locked);
    end
    e = 4'd4;
    for (int m = 1; m <= 5; m++) begin
      b = e + 4'd5;
      step(1'b1, b);
      tests++;
      if ({d2_err_pulse, d2_err_count, err_count} !== {1'b1, 2'((m > 3) ? 3 : m), 8'(m)}) begin
        fails++; $display("FAIL sat_err[%0d] got_d2=%0d got=%0d exp_d2=%0d exp=%0d",
                          m, d2_err_count, err_count, (m > 3) ? 3 : m, m);
      end
      step(1'b1, b + 4'd1);
      step(1'b1, b + 4'd2);
      step(1'b1, b + 4'd3);
      tests++;
      if (d2_locked !== 1'b1) begin
        fails++; $display("FAIL sat_relock[%0d] got=%0b exp=1", m, d2_locked);
      end
      e = b + 4'd4;
    end
    rst = 1'b1;
    step(1'b1, e);
    rst = 1'b0;
    tests++;
    if (snap() !== mk(0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL rst_mid got=%h exp=%h", snap(), mk(0, 0, 0, 0, 0, 0));
    end
    tests++;
    if ({d2_locked, d2_err_pulse, d2_stall, d2_expected, d2_err_count, d2_wrap_count} !== 11'd0) begin
      fails++; $display("FAIL rst_mid_d2 got_err=%0d got_lock=%0b exp=0", d2_err_count, d2_locked);
    end
    step(1'b1, 4'd5);
    tests++;
    if (snap() !== mk(0, 0, 0, 6, 0, 0)) begin
      fails++; $display("FAIL rst_sync got=%h exp=%h", snap(), mk(0, 0, 0, 6, 0, 0));
    end
    step(1'b1, 4'd6);
    step(1'b1, 4'd7);
    step(1'b1, 4'd8);
    tests++;
    if (snap() !== mk(1, 0, 0, 9, 0, 0)) begin
      fails++; $display("FAIL rst_relock got=%h exp=%h", snap(), mk(1, 0, 0, 9, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_wrap();
    test_mismatch();
    test_stall();
    test_enable();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Receiving end of the free-running counter output bus.
- Samples the WIDTH-bit count each enabled clock and checks that it advances by exactly +1 modulo 2^WIDTH.
- Reports lock status, mismatch errors, wrap-arounds and stalls.
- Sits beside the counter in benches and on-chip debug as a self-checking sink.

Parameters:
WIDTH, 4, width of the monitored count bus
LOCK_N, 3, consecutive correct increments required to declare lock
STALL_LIMIT, 8, consecutive identical samples that assert stall (2..255)
CNT_W, 8, width of error and wrap statistic counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  sample enable; cnt_in is sampled only when en=1
cnt_in  input  WIDTH  count value from the counter under observation
locked  output  1  high while in TRACK state
err_pulse  output  1  one-cycle pulse on a mismatch detected in TRACK
err_count  output  CNT_W  saturating count of TRACK mismatches
wrap_count  output  CNT_W  saturating count of correct max->0 transitions in TRACK
stall  output  1  high while repeat run length >= STALL_LIMIT
expected  output  WIDTH  next value the monitor expects

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All state updates on rising clk. All outputs are registered and reflect the sample taken at the previous enabled edge (1-cycle latency).
- Reset: state=SYNC; locked=0, err_pulse=0, err_count=0, wrap_count=0, stall=0, expected=0; match run counter and repeat run counter = 0. Reset has priority over en. Reset mid-TRACK clears everything in the same edge.
- en=0: no state change. err_pulse is forced to 0. Counters and stall hold.
- Match definition: cnt_in == expected. On every enabled sample, expected <= cnt_in + 1, truncated to WIDTH, so all-ones wraps to 0.
- FSM, evaluated only when en=1:
  - SYNC: first sample loads expected. Run counter=0. Go to ACQ.
  - ACQ, match: run counter++. If it reaches LOCK_N, go to TRACK, set locked=1, clear the run counter.
  - ACQ, mismatch: run counter=0, stay in ACQ. No err_pulse and no err_count change.
  - TRACK, match: stay. If cnt_in==0, wrap_count++ (saturate at 2^CNT_W-1).
  - TRACK, mismatch: err_pulse=1 for that cycle, err_count++ (saturating), locked=0, go to ACQ. expected resyncs to cnt_in+1.
- Stall detection:
  - Repeat counter holds the number of consecutive enabled samples equal to the previous enabled sample. It saturates at STALL_LIMIT and resets to 0 on any change.
  - stall=1 while repeat counter >= STALL_LIMIT-1 (i.e. STALL_LIMIT identical samples). It clears on the first differing sample.
  - A stall in TRACK also produces a mismatch on the first repeated sample; both are reported independently.
- Simultaneous events: a wrap and a stall cannot coincide. A mismatch in TRACK that lands on value 0 does not count as a wrap.
- Saturation: err_count and wrap_count stick at all-ones until rst.

Test Plan:
1. Reset, then en=1 with cnt_in counting 0,1,2,3,4 each cycle.
   - locked rises one cycle after the sample of value 3: SYNC at 0, matches at 1, 2, 3.
   - err_count=0. expected=5 after the sample of value 4.
2. Locked stream 13,14,15,0,1.
   - wrap_count increments 0->1 one cycle after the 0 sample.
   - No err_pulse. locked stays 1.
3. Locked stream 5,6,9,10,11,12.
   - err_pulse=1 for exactly one cycle after the 9 sample; err_count=1; locked drops.
   - locked returns after the 12 sample (10, 11, 12 match).
4. Locked, then cnt_in held at 7 for 10 enabled cycles.
   - One err_pulse on the first repeat.
   - stall=1 after the 8th identical sample; clears after the next differing value.
5. Toggle en=0 for 5 cycles while cnt_in jumps randomly mid-TRACK.
   - No err_pulse and no state change.
   - Resuming with the correct next value keeps locked=1.
6. CNT_W=2 with 5 forced mismatches in TRACK: err_count saturates at 3. Then assert rst mid-stream: all outputs are 0 and state is SYNC on the next cycle.
